// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA transfer scheduler.
//   dma_desc_t      1D transfer descriptor (src, dst, len) as held per backend stream.
//   stream_state_e  per-stream lifecycle: idle, issuing to the backend, waiting for done.
//   idx_width()     index width helper that stays >= 1 for single-entry cases.
package dma_sched_pkg;

    // Storage widths of the descriptor registers. The scheduler's AddrWidth/LenWidth
    // parameters must not exceed these.
    localparam int unsigned DmaAddrWidth = 64;
    localparam int unsigned DmaLenWidth  = 32;

    typedef struct packed {
        logic [DmaAddrWidth-1:0] src;
        logic [DmaAddrWidth-1:0] dst;
        logic [DmaLenWidth-1:0]  len;
    } dma_desc_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } stream_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_sched_rr_arb.sv
// Generic NumReq-way round-robin arbiter.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         request vector
//   advance_i     move the priority pointer past the current winner
//   gnt_o         one-hot grant (zero when no request)
//   idx_o         index of the granted requester
module dma_sched_rr_arb
    import dma_sched_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              advance_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;
    logic            found;

    // Scan starting at the pointer; the first requester found wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NumReq);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dma_tf_scheduler.sv
// Transfer scheduler: shares NumStreams DMA backend streams among NumReq requesters.
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid_i / req_ready_o         per-requester descriptor handshake (one grant per cycle)
//   req_src_i, req_dst_i, req_len_i   per-requester descriptor
//   be_valid_o / be_ready_i           per-stream descriptor handshake
//   be_src_o, be_dst_o, be_len_o      per-stream registered descriptor
//   be_done_i                         per-stream completion pulse (valid only while waiting)
//   done_o                            per-requester completion pulse, serialized
//   busy_o                            any stream active or any completion/credit outstanding
module dma_tf_scheduler
    import dma_sched_pkg::*;
#(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned NumStreams   = 4,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned LenWidth     = 32,
    parameter int unsigned MaxOutPerReq = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     req_valid_i,
    output logic [NumReq-1:0]                     req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]      req_src_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]      req_dst_i,
    input  logic [NumReq-1:0][LenWidth-1:0]       req_len_i,
    output logic [NumStreams-1:0]                 be_valid_o,
    input  logic [NumStreams-1:0]                 be_ready_i,
    output logic [NumStreams-1:0][AddrWidth-1:0]  be_src_o,
    output logic [NumStreams-1:0][AddrWidth-1:0]  be_dst_o,
    output logic [NumStreams-1:0][LenWidth-1:0]   be_len_o,
    input  logic [NumStreams-1:0]                 be_done_i,
    output logic [NumReq-1:0]                     done_o,
    output logic                                  busy_o
);

    localparam int unsigned OwnW  = idx_width(NumReq);
    localparam int unsigned StrmW = idx_width(NumStreams);
    localparam int unsigned CntW  = $clog2(MaxOutPerReq + 1);
    localparam int unsigned PendW = $clog2(NumStreams + 2);
    localparam int unsigned AvW   = PendW + 1;

    // Per-stream state
    stream_state_e   state_q [NumStreams];
    logic [OwnW-1:0] owner_q [NumStreams];
    dma_desc_t       desc_q  [NumStreams];

    // Per-requester counters. pend_nz_q is the subset of pend_done_q that came from
    // stream completions, so zero-length pulses never hand back a credit.
    logic [CntW-1:0]  out_cnt_q   [NumReq];
    logic [CntW-1:0]  out_cnt_d   [NumReq];
    logic [PendW-1:0] pend_done_q [NumReq];
    logic [PendW-1:0] pend_done_d [NumReq];
    logic [PendW-1:0] pend_nz_q   [NumReq];
    logic [PendW-1:0] pend_nz_d   [NumReq];
    logic [PendW-1:0] strm_comp   [NumReq];
    logic [AvW-1:0]   avail       [NumReq];
    logic [AvW-1:0]   avail_nz    [NumReq];
    logic [NumReq-1:0] done_q;
    logic [NumReq-1:0] fire, fire_nz;

    logic [NumReq-1:0] len_zero, eligible, gnt, acc_nz, zl_acc;
    logic [OwnW-1:0]   win_idx;
    logic              any_idle;
    logic [StrmW-1:0]  alloc_idx;
    logic              accept_nz;

    // Lowest-index idle stream
    always_comb begin
        any_idle  = 1'b0;
        alloc_idx = '0;
        for (int s = NumStreams - 1; s >= 0; s--) begin
            if (state_q[s] == StIdle) begin
                any_idle  = 1'b1;
                alloc_idx = StrmW'(s);
            end
        end
    end

    // Eligibility; requests are masked during reset so ready stays low.
    always_comb begin
        for (int r = 0; r < NumReq; r++) begin
            len_zero[r] = (req_len_i[r] == '0);
            eligible[r] = req_valid_i[r] && !rst_i
                          && (out_cnt_q[r] < CntW'(MaxOutPerReq))
                          && (len_zero[r] || any_idle);
        end
    end

    dma_sched_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (OwnW)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (eligible),
        .advance_i (|gnt),
        .gnt_o     (gnt),
        .idx_o     (win_idx)
    );

    assign req_ready_o = gnt;
    assign acc_nz      = gnt & ~len_zero;
    assign zl_acc      = gnt & len_zero;
    assign accept_nz   = |acc_nz;

    // Stream FSMs and descriptor capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NumStreams; s++) begin
                state_q[s] <= StIdle;
                owner_q[s] <= '0;
                desc_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NumStreams; s++) begin
                case (state_q[s])
                    StIdle: begin
                        if (accept_nz && (alloc_idx == StrmW'(s))) begin
                            state_q[s]    <= StIssue;
                            owner_q[s]    <= win_idx;
                            desc_q[s].src <= DmaAddrWidth'(req_src_i[win_idx]);
                            desc_q[s].dst <= DmaAddrWidth'(req_dst_i[win_idx]);
                            desc_q[s].len <= DmaLenWidth'(req_len_i[win_idx]);
                        end
                    end
                    StIssue: if (be_ready_i[s]) state_q[s] <= StWait;
                    StWait:  if (be_done_i[s]) state_q[s] <= StIdle;
                    default: state_q[s] <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NumStreams; s++) begin
            be_valid_o[s] = (state_q[s] == StIssue);
            be_src_o[s]   = AddrWidth'(desc_q[s].src);
            be_dst_o[s]   = AddrWidth'(desc_q[s].dst);
            be_len_o[s]   = LenWidth'(desc_q[s].len);
        end
    end

    // Route completions to owners
    always_comb begin
        for (int r = 0; r < NumReq; r++) begin
            strm_comp[r] = '0;
        end
        for (int s = 0; s < NumStreams; s++) begin
            if ((state_q[s] == StWait) && be_done_i[s]) begin
                strm_comp[owner_q[s]] = strm_comp[owner_q[s]] + PendW'(1);
            end
        end
    end

    // Completions arriving this cycle count toward the next done_o pulse, which
    // consumes one pending entry; extra completions queue up one pulse per cycle.
    always_comb begin
        for (int r = 0; r < NumReq; r++) begin
            avail[r]       = AvW'(pend_done_q[r]) + AvW'(strm_comp[r]) + AvW'(zl_acc[r]);
            fire[r]        = (avail[r] != '0);
            pend_done_d[r] = PendW'(avail[r] - AvW'(fire[r]));
            avail_nz[r]    = AvW'(pend_nz_q[r]) + AvW'(strm_comp[r]);
            fire_nz[r]     = fire[r] && (avail_nz[r] != '0);
            pend_nz_d[r]   = PendW'(avail_nz[r] - AvW'(fire_nz[r]));
            out_cnt_d[r]   = out_cnt_q[r] + CntW'(acc_nz[r]) - CntW'(fire_nz[r]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumReq; r++) begin
                out_cnt_q[r]   <= '0;
                pend_done_q[r] <= '0;
                pend_nz_q[r]   <= '0;
            end
            done_q <= '0;
        end else begin
            for (int r = 0; r < NumReq; r++) begin
                out_cnt_q[r]   <= out_cnt_d[r];
                pend_done_q[r] <= pend_done_d[r];
                pend_nz_q[r]   <= pend_nz_d[r];
            end
            done_q <= fire;
        end
    end

    assign done_o = done_q;

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < NumStreams; s++) begin
            if (state_q[s] != StIdle) busy_o = 1'b1;
        end
        for (int r = 0; r < NumReq; r++) begin
            if ((out_cnt_q[r] != '0) || (pend_done_q[r] != '0)) busy_o = 1'b1;
        end
    end

    // A backend may only signal done for a descriptor it has accepted.
    for (genvar s = 0; s < NumStreams; s++) begin : g_done_chk
        assert property (@(posedge clk_i) disable iff (rst_i)
                         be_done_i[s] |-> (state_q[s] == StWait));
    end

endmodule

// File: tb/tb_dma_tf_scheduler.sv
module tb_dma_tf_scheduler;

    localparam int NR   = 4;
    localparam int NS   = 4;
    localparam int AW   = 64;
    localparam int LW   = 32;
    localparam int MAXO = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0]          req_valid, req_ready;
    logic [NR-1:0][AW-1:0]  req_src, req_dst;
    logic [NR-1:0][LW-1:0]  req_len;
    logic [NS-1:0]          be_valid, be_ready, be_done;
    logic [NS-1:0][AW-1:0]  be_src, be_dst;
    logic [NS-1:0][LW-1:0]  be_len;
    logic [NR-1:0]          done;
    logic                   busy;

    always #5 clk = ~clk;

    dma_tf_scheduler #(
        .NumReq       (NR),
        .NumStreams   (NS),
        .AddrWidth    (AW),
        .LenWidth     (LW),
        .MaxOutPerReq (MAXO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_src_i   (req_src),
        .req_dst_i   (req_dst),
        .req_len_i   (req_len),
        .be_valid_o  (be_valid),
        .be_ready_i  (be_ready),
        .be_src_o    (be_src),
        .be_dst_o    (be_dst),
        .be_len_o    (be_len),
        .be_done_i   (be_done),
        .done_o      (done),
        .busy_o      (busy)
    );

    typedef struct {
        logic [3:0] v, z, br, bd;   // valid, zero-length mask, be_ready, be_done
        logic [3:0] er, ev, ed;     // expected req_ready, be_valid, done_o
        logic       eb;             // expected busy_o
    } vec_t;

    // Reference model: transfers in flight per stream, counters as plain integers.
    bit          m_alloc  [NS];
    bit          m_issued [NS];
    int          m_owner  [NS];
    logic [63:0] m_src [NS], m_dst [NS];
    logic [31:0] m_len [NS];
    int          m_ptr;
    int          m_out [NR], m_pend [NR], m_strm [NR];
    bit          m_done [NR];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] v, z, br, bd, er, ev, ed, input logic eb);
        vec_t t;
        t.v = v; t.z = z; t.br = br; t.bd = bd; t.er = er; t.ev = ev; t.ed = ed; t.eb = eb;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_alloc[s] = 0; m_issued[s] = 0; m_owner[s] = 0;
        end
        for (int r = 0; r < NR; r++) begin
            m_out[r] = 0; m_pend[r] = 0; m_strm[r] = 0; m_done[r] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic drive(input logic [3:0] v, z, br, bd);
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = v[r];
            req_len[r]   = z[r] ? 32'd0 : 32'(64 + 16 * r);
            req_src[r]   = {32'(32'hA000_0000 + r), 32'(cyc)};
            req_dst[r]   = {32'(32'hB000_0000 + r), ~32'(cyc)};
        end
        be_ready = br;
        be_done  = bd;
    endtask

    // Called just after inputs change at a negedge; checks, advances the model, and
    // returns at the next negedge.
    task automatic step(input bit has_exp, input vec_t t);
        int win, free_idx, r;
        int comp [NR];
        int zl [NR];
        logic [NR-1:0] e_rdy, e_done;
        logic [NS-1:0] e_bev;
        bit e_busy;
        #1;
        free_idx = -1;
        for (int s = 0; s < NS; s++) if (!m_alloc[s] && free_idx < 0) free_idx = s;
        win = -1;
        for (int i = 0; i < NR; i++) begin
            r = (m_ptr + i) % NR;
            if (win < 0 && req_valid[r] && m_out[r] < MAXO && (req_len[r] == 0 || free_idx >= 0))
                win = r;
        end
        e_rdy = '0;
        if (win >= 0) e_rdy[win] = 1'b1;
        e_busy = 0;
        for (int s = 0; s < NS; s++) begin
            e_bev[s] = m_alloc[s] && !m_issued[s];
            if (m_alloc[s]) e_busy = 1;
        end
        for (int i = 0; i < NR; i++) begin
            e_done[i] = m_done[i];
            if (m_out[i] != 0 || m_pend[i] != 0) e_busy = 1;
        end
        check("req_ready", 64'(req_ready), 64'(e_rdy));
        check("be_valid", 64'(be_valid), 64'(e_bev));
        check("done_o", 64'(done), 64'(e_done));
        check("busy_o", 64'(busy), 64'(e_busy));
        for (int s = 0; s < NS; s++) begin
            if (e_bev[s] && be_valid[s]) begin
                check("be_src", be_src[s], m_src[s]);
                check("be_dst", be_dst[s], m_dst[s]);
                check("be_len", 64'(be_len[s]), 64'(m_len[s]));
            end
        end
        if (has_exp) begin
            check("tbl_req_ready", 64'(req_ready), 64'(t.er));
            check("tbl_be_valid", 64'(be_valid), 64'(t.ev));
            check("tbl_done_o", 64'(done), 64'(t.ed));
            check("tbl_busy_o", 64'(busy), 64'(t.eb));
        end
        // Advance the model by one clock
        for (int i = 0; i < NR; i++) begin
            comp[i] = 0; zl[i] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            if (m_alloc[s] && m_issued[s] && be_done[s]) begin
                comp[m_owner[s]]++;
                m_alloc[s] = 0; m_issued[s] = 0;
            end else if (m_alloc[s] && !m_issued[s] && be_ready[s]) begin
                m_issued[s] = 1;
            end
        end
        if (win >= 0) begin
            m_ptr = (win + 1) % NR;
            if (req_len[win] == 0) begin
                zl[win] = 1;
            end else begin
                m_alloc[free_idx]  = 1;
                m_issued[free_idx] = 0;
                m_owner[free_idx]  = win;
                m_src[free_idx]    = req_src[win];
                m_dst[free_idx]    = req_dst[win];
                m_len[free_idx]    = req_len[win];
                m_out[win]++;
            end
        end
        for (int i = 0; i < NR; i++) begin
            m_pend[i] += comp[i] + zl[i];
            m_strm[i] += comp[i];
            m_done[i] = (m_pend[i] > 0);
            if (m_pend[i] > 0) begin
                m_pend[i]--;
                if (m_strm[i] > 0) begin
                    m_strm[i]--;
                    m_out[i]--;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] saved_src;
        logic [3:0]  v, z, br, bd;
        vec_t none;
        none = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        // Fill the directed table: round robin, stall, zero-length, single transfer,
        // credit limit, simultaneous completions.
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h0, 4'h2, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h0, 4'h4, 4'h2, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h0, 4'h8, 4'h4, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 4'h0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(4'h6, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'h2, 4'h0, 4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0));
        tbl.push_back(mk(4'h8, 4'h8, 4'hF, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'h5, 4'h0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h8, 1'b0));
        tbl.push_back(mk(4'h5, 4'h0, 4'hF, 4'h0, 4'h4, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(4'h5, 4'h0, 4'hF, 4'h0, 4'h1, 4'h2, 4'h0, 1'b1));
        tbl.push_back(mk(4'h5, 4'h0, 4'hF, 4'h0, 4'h4, 4'h4, 4'h0, 1'b1));
        tbl.push_back(mk(4'h1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8, 4'h0, 1'b1));
        tbl.push_back(mk(4'h1, 4'h0, 4'hF, 4'hA, 4'h0, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'h1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1));
        tbl.push_back(mk(4'h1, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h4, 1'b1));
        tbl.push_back(mk(4'h1, 4'h0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));

        // Reset with requests pending: nothing may be granted
        rst = 1'b1;
        drive(4'hF, 4'h0, 4'h0, 4'h0);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_be_valid", 64'(be_valid), 64'd0);
        check("reset_done_o", 64'(done), 64'd0);
        check("reset_busy_o", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].z, tbl[i].br, tbl[i].bd);
            step(1'b1, tbl[i]);
        end

        // Reset while stream 0 is issuing and stream 2 is waiting
        drive(4'hF, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_be_valid", 64'(be_valid), 64'd0);
        check("midrst_done_o", 64'(done), 64'd0);
        check("midrst_busy_o", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(4'h8, 4'h0, 4'h0, 4'h0);
        saved_src = req_src[3];
        step(1'b1, mk(4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0));
        drive(4'h0, 4'h0, 4'h1, 4'h0);
        #1;
        check("post_rst_src", be_src[0], saved_src);
        check("post_rst_len", 64'(be_len[0]), 64'd112);
        step(1'b1, mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v  = 4'($urandom_range(0, 15));
            z  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            br = 4'($urandom_range(0, 15));
            bd = '0;
            for (int s = 0; s < NS; s++)
                bd[s] = m_alloc[s] && m_issued[s] && ($urandom_range(0, 3) == 0);
            drive(v, z, br, bd);
            for (int r = 0; r < NR; r++)
                if (!z[r]) req_len[r] = 32'($urandom_range(1, 32'h00FF_FFFF));
            step(1'b0, none);
        end

        // Drain everything and confirm the block goes idle
        for (int n = 0; n < 40; n++) begin
            bd = '0;
            for (int s = 0; s < NS; s++) bd[s] = m_alloc[s] && m_issued[s];
            drive(4'h0, 4'h0, 4'hF, bd);
            step(1'b0, none);
        end
        #1;
        check("drain_busy_o", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
